muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EXE stage. It replaces the fixed 32-bit divider and the single-cycle multiply path with one shared engine. The engine accepts signed and unsigned MULT/DIV (optionally MADD/MSUB) over a start/done handshake and returns a HI/LO pair. EXE holds the pipeline while `busy_o` is high, and drives `flush_i` on exceptions so an in-flight operation never retires.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_unit_div_core.sv | 87 ++++++++
 rtl/muldiv_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and helpers for the EXE-stage multiply/divide engine.
//   muldiv_op_t : 3-bit opcode (MULT..MSUBU)
//   state_t     : engine FSM state
//   is_signed() : opcode treats operands as two's complement
//   is_div()    : opcode is a divide
// -----------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MADD  = 3'd4,
      MADDU = 3'd5,
      MSUB  = 3'd6,
      MSUBU = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   function automatic logic is_signed(muldiv_op_t op);
      return op inside {MULT, DIV, MADD, MSUB};
   endfunction

   function automatic logic is_div(muldiv_op_t op);
      return op inside {DIV, DIVU};
   endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// -----------------------------------------------------------------------------
// div_core
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// cycle. The first iteration is performed on the load edge itself, so the
// final quotient/remainder are available WIDTH-1 cycles after load.
// Requires WIDTH >= 2.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   load_i       : start a division with dividend_i / divisor_i
//   cancel_i     : abandon the division in progress
//   dividend_i   : dividend magnitude
//   divisor_i    : divisor magnitude
//   q_o, r_o     : quotient / remainder (valid once last_o has passed)
//   last_o       : the final iteration happens at the coming edge
// -----------------------------------------------------------------------------
module div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             cancel_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] r_o,
   output logic             last_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0] rem_src, quo_src, dvs_src;
   logic [WIDTH-1:0] rem_d, quo_d;
   logic [WIDTH:0]   trial;
   logic             ge;

   // quo_q holds the not-yet-consumed dividend bits at the top and the
   // quotient bits shifting in at the bottom.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      rem_src = rem_q;
      quo_src = quo_q;
      dvs_src = dvs_q;
      if (load_i) begin
         rem_src = '0;
         quo_src = dividend_i;
         dvs_src = divisor_i;
      end
      trial = {rem_src, quo_src[WIDTH-1]};
      ge    = (trial >= {1'b0, dvs_src});
      // When ge holds the difference is below the divisor, so the low
      // WIDTH bits of the subtraction are exact.
      rem_d = ge ? (trial[WIDTH-1:0] - dvs_src) : trial[WIDTH-1:0];
      quo_d = {quo_src[WIDTH-2:0], ge};
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst || cancel_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= CW'(WIDTH - 1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   // NOTE: datapath registers carry no reset; they are only consumed while
   // cnt_q or the parent FSM marks them valid, and both of those are reset.
   always_ff @(posedge clk) begin
      if (load_i || cnt_q != '0) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_src;
      end
   end

   assign q_o    = quo_q;
   assign r_o    = rem_q;
   assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Shared multi-cycle multiply/divide engine for the EXE stage.
//   Multiply : full 2*WIDTH product, done MUL_LAT cycles after accept.
//   Divide   : restoring divide on magnitudes + sign fix-up, done WIDTH+1
//              cycles after accept.
// Configuration macro: MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// ({hi_i,lo_i} +/- product); when undefined those codes are ignored.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   start_i, op_i      : request and opcode (accepted only when idle)
//   a_i, b_i           : rs / rt operands
//   hi_i, lo_i         : forwarded HI/LO for accumulate ops
//   flush_i            : cancel in-flight work, no result is produced
//   busy_o             : operation in flight (through the done cycle)
//   done_o             : one-cycle result-valid pulse
//   hi_o, lo_o         : registered result (remainder / quotient for divide)
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int W2 = 2 * WIDTH;

   muldiv_op_t       op;
   state_t           state_q, state_d;
   logic             done_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic op_mul, op_sgn, accept, acc_mul, acc_div;

   assign op     = muldiv_op_t'(op_i);
   assign op_sgn = is_signed(op);
`ifdef MULDIV_MADD_EN
   assign op_mul = !is_div(op);
`else
   assign op_mul = (op == MULT) || (op == MULTU);
`endif

   // busy_o covers the done cycle, so the earliest next accept is the cycle
   // after done_o and back-to-back spacing is latency+1.
   assign busy_o  = (state_q != ST_IDLE) || done_q;
   assign accept  = start_i && !flush_i && !busy_o;
   assign acc_mul = accept && op_mul;
   assign acc_div = accept && is_div(op);

   // ---------------------------------------------------------------- multiply
   logic [W2-1:0] a_ext, b_ext, prod, mul_res;

   // Sign- or zero-extending to 2*WIDTH makes one unsigned multiplier give
   // the correct low 2*WIDTH bits for both signed and unsigned ops.
   assign a_ext = op_sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
   assign b_ext = op_sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
   assign prod  = a_ext * b_ext;

`ifdef MULDIV_MADD_EN
   logic [W2-1:0] acc;
   assign acc = {hi_i, lo_i};

   always_comb begin
      mul_res = prod;
      if (op inside {MADD, MADDU}) begin
         mul_res = acc + prod;
      end else if (op inside {MSUB, MSUBU}) begin
         mul_res = acc - prod;
      end
   end
`else
   logic [W2-1:0] unused_acc;
   assign unused_acc = {hi_i, lo_i};
   assign mul_res    = prod;
`endif

   // Result is computed on the accept edge and then rides MUL_LAT-1 pipeline
   // stages; the output register is the last of the MUL_LAT stages.
   logic          mul_out_vld;
   logic [W2-1:0] mul_out_dat;

   generate
      if (MUL_LAT == 1) begin : g_mul_direct
         assign mul_out_vld = acc_mul;
         assign mul_out_dat = mul_res;
      end else begin : g_mul_pipe
         logic [MUL_LAT-2:0] vld_q;
         logic [W2-1:0]      dat_q [MUL_LAT-1];

         always_ff @(posedge clk) begin
            if (!rst || flush_i) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= acc_mul;
               for (int i = 1; i < MUL_LAT - 1; i++) begin
                  vld_q[i] <= vld_q[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            dat_q[0] <= mul_res;
            for (int i = 1; i < MUL_LAT - 1; i++) begin
               dat_q[i] <= dat_q[i-1];
            end
         end

         assign mul_out_vld = vld_q[MUL_LAT-2];
         assign mul_out_dat = dat_q[MUL_LAT-2];
      end
   endgenerate

   // ------------------------------------------------------------------ divide
   logic [WIDTH-1:0] a_mag, b_mag, div_q, div_r;
   logic             div_last;
   logic [WIDTH-1:0] dvd_q;
   logic             neg_quo_q, neg_rem_q, dbz_q;

   assign a_mag = (op_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_mag = (op_sgn && b_i[WIDTH-1]) ? -b_i : b_i;

   div_core #(
      .WIDTH(WIDTH)
   ) u_div_core (
      .clk        (clk),
      .rst        (rst),
      .load_i     (acc_div),
      .cancel_i   (flush_i),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .q_o        (div_q),
      .r_o        (div_r),
      .last_o     (div_last)
   );

   always_ff @(posedge clk) begin
      if (acc_div) begin
         dvd_q     <= a_i;
         neg_quo_q <= op_sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
         neg_rem_q <= op_sgn && a_i[WIDTH-1];
         dbz_q     <= (b_i == '0);
      end
   end

   // Most-negative / -1 needs no special case: |MIN| is MIN as an unsigned
   // magnitude, and negating it wraps back to MIN with a zero remainder.
   logic [WIDTH-1:0] fix_hi, fix_lo;

   always_comb begin
      fix_lo = neg_quo_q ? -div_q : div_q;
      fix_hi = neg_rem_q ? -div_r : div_r;
      if (dbz_q) begin
         fix_lo = '1;
         fix_hi = dvd_q;
      end
   end

   // --------------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (acc_mul) begin
               state_d = (MUL_LAT == 1) ? ST_IDLE : ST_MUL;
            end else if (acc_div) begin
               state_d = ST_DIV;
            end
         end
         ST_MUL: if (mul_out_vld) state_d = ST_IDLE;
         ST_DIV: if (div_last)    state_d = ST_FIX;
         ST_FIX: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------ result
   logic          res_we;
   logic [W2-1:0] res;

   assign res_we = !flush_i && (mul_out_vld || state_q == ST_FIX);
   assign res    = (state_q == ST_FIX) ? {fix_hi, fix_lo} : mul_out_dat;

   always_ff @(posedge clk) begin
      if (!rst) begin
         done_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         done_q <= res_we;
         if (res_we) begin
            {hi_q, lo_q} <= res;
         end
      end
   end

   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_LAT=2): a table of known
// vectors, randomized operations against an arithmetic reference model, and
// hand-written sequences for busy-start, flush, flush+start, unknown opcodes
// and mid-operation reset. Honours MULDIV_MADD_EN for the accumulate ops.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W    = 32;
   localparam int LAT  = 2;
   localparam int DLAT = W + 1;
   localparam int TMO  = 200;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i, flush_i;
   logic [2:0]    op_i;
   logic [W-1:0]  a_i, b_i, hi_i, lo_i;
   logic          busy_o, done_o;
   logic [W-1:0]  hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_unit #(
      .WIDTH   (W),
      .MUL_LAT (LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .hi_i    (hi_i),
      .lo_i    (lo_i),
      .flush_i (flush_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   typedef struct {
      muldiv_op_t  op;
      logic [31:0] a, b, hin, lin;
      logic [31:0] ehi, elo;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit integer arithmetic; result packed as {hi, lo}.
   function automatic logic [63:0] ref_result(muldiv_op_t op, logic [31:0] a, logic [31:0] b,
                                              logic [31:0] hin, logic [31:0] lin);
      int              sa, sb;
      longint          sp;
      longint unsigned up, acc;
      sa  = a;
      sb  = b;
      sp  = longint'(sa) * longint'(sb);
      up  = {32'b0, a} * {32'b0, b};
      acc = {hin, lin};
      case (op)
         MULT:  return sp;
         MULTU: return up;
         MADD:  return acc + sp;
         MADDU: return acc + up;
         MSUB:  return acc - sp;
         MSUBU: return acc - up;
         DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic vec_t mk(muldiv_op_t op, logic [31:0] a, logic [31:0] b, logic [31:0] hin,
                               logic [31:0] lin, logic [31:0] ehi, logic [31:0] elo, string name);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.hin = hin; v.lin = lin;
      v.ehi = ehi; v.elo = elo; v.name = name;
      v.lat = is_div(op) ? DLAT : LAT;
      return v;
   endfunction

   task automatic drive_idle();
      start_i = 1'b0;
      flush_i = 1'b0;
      op_i    = 3'd0;
      a_i     = '0;
      b_i     = '0;
      hi_i    = '0;
      lo_i    = '0;
   endtask

   // Issues one op and follows it to the cycle after done_o.
   task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hin, input logic [31:0] lin, input int exp_lat,
                         input logic [31:0] ehi, input logic [31:0] elo, input string name);
      int cyc;
      @(negedge clk);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b; hi_i = hin; lo_i = lin;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 1;
      check({name, "_busy1"}, 64'(busy_o), 64'd1);
      while (!done_o && cyc < TMO) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_lat"}, 64'(cyc), 64'(exp_lat));
      check({name, "_res"}, {hi_o, lo_o}, {ehi, elo});
      @(negedge clk);
      check({name, "_after"}, {30'd0, busy_o, done_o, hi_o, lo_o}, {32'd0, ehi, elo});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      drive_idle();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      check("reset_state", {30'd0, busy_o, done_o, hi_o, lo_o}, 64'd0);

      // ---- table of known vectors
      vecs.push_back(mk(MULT,  32'hFFFF_FFFF, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg1x2"));
      vecs.push_back(mk(MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'h0000_0001, 32'hFFFF_FFFE, "multu_max_x2"));
      vecs.push_back(mk(MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, 32'h0, "mult_minxmin"));
      vecs.push_back(mk(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h1, "multu_maxsq"));
      vecs.push_back(mk(DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"));
      vecs.push_back(mk(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h8000_0000, "div_min_m1"));
      vecs.push_back(mk(DIV,   32'd7, 32'hFFFF_FFFE, 0, 0, 32'd1, 32'hFFFF_FFFD, "div_7_m2"));
      vecs.push_back(mk(DIV,   32'hFFFF_FFF9, 32'd0, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0"));
      vecs.push_back(mk(DIVU,  32'd100, 32'd7, 0, 0, 32'd2, 32'd14, "divu_100_7"));
`ifdef MULDIV_MADD_EN
      vecs.push_back(mk(MADD,  32'd3, 32'd4, 32'd0, 32'd5, 32'd0, 32'd17, "madd_3x4_p5"));
      vecs.push_back(mk(MSUBU, 32'd3, 32'd4, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "msubu_3x4_p5"));
`endif
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hin, vecs[i].lin, vecs[i].lat,
                vecs[i].ehi, vecs[i].elo, vecs[i].name);
      end

      // ---- randomized ops against the reference model
      for (int i = 0; i < 30; i++) begin
         muldiv_op_t  op;
         logic [31:0] a, b, hin, lin;
         logic [63:0] e;
`ifdef MULDIV_MADD_EN
         op = muldiv_op_t'($urandom_range(0, 7));
`else
         op = muldiv_op_t'($urandom_range(0, 3));
`endif
         a   = $urandom;
         b   = $urandom;
         hin = $urandom;
         lin = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         e = ref_result(op, a, b, hin, lin);
         run_op(op, a, b, hin, lin, is_div(op) ? DLAT : LAT, e[63:32], e[31:0],
                $sformatf("rand%0d_op%0d", i, op));
      end

      // ---- start while busy is ignored (DIVU 7/0, stray MULTU in cycle 5)
      begin
         int cyc;
         @(negedge clk);
         start_i = 1'b1; op_i = DIVU; a_i = 32'd7; b_i = 32'd0;
         @(negedge clk);
         start_i = 1'b0;
         cyc = 1;
         while (!done_o && cyc < TMO) begin
            if (cyc == 5) begin
               start_i = 1'b1; op_i = MULTU; a_i = 32'd3; b_i = 32'd4;
            end else begin
               start_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
         start_i = 1'b0;
         check("busy_start_lat", 64'(cyc), 64'(DLAT));
         check("busy_start_res", {hi_o, lo_o}, {32'd7, 32'hFFFF_FFFF});
         seen = 1'b0;
         repeat (6) begin
            @(negedge clk);
            if (done_o || busy_o) seen = 1'b1;
         end
         check("busy_start_no_extra", 64'(seen), 64'd0);
      end

      // ---- flush in cycle 10 of DIVU 100/7, then MULTU 3x4 in cycle 11
      run_op(MULTU, 32'd5, 32'd6, 0, 0, LAT, 32'd0, 32'd30, "pre_flush");
      @(negedge clk);
      start_i = 1'b1; op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      seen = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (done_o) seen = 1'b1;
         @(negedge clk);
      end
      if (done_o) seen = 1'b1;
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_busy_c11", 64'(busy_o), 64'd0);
      check("flush_hold_c11", {hi_o, lo_o}, {32'd0, 32'd30});
      start_i = 1'b1; op_i = MULTU; a_i = 32'd3; b_i = 32'd4;
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) seen = 1'b1;
      check("flush_no_done", 64'(seen), 64'd0);
      check("flush_hold_c12", {31'd0, busy_o, hi_o, lo_o}, {32'd1, 32'd0, 32'd30});
      @(negedge clk);
      check("post_flush_mul_c13", {31'd0, done_o, hi_o, lo_o}, {32'd1, 32'd0, 32'd12});

      // ---- start together with flush is not accepted
      @(negedge clk);
      start_i = 1'b1; flush_i = 1'b1; op_i = MULT; a_i = 32'd9; b_i = 32'd9;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      check("start_flush_busy", 64'(busy_o), 64'd0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done_o) seen = 1'b1;
      end
      check("start_flush_no_done", {31'd0, seen, hi_o, lo_o}, {32'd0, 32'd0, 32'd12});

      // ---- accumulate opcodes are unknown without the option
`ifndef MULDIV_MADD_EN
      @(negedge clk);
      start_i = 1'b1; op_i = MADD; a_i = 32'd3; b_i = 32'd4;
      @(negedge clk);
      start_i = 1'b0;
      check("unknown_op_busy", 64'(busy_o), 64'd0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done_o || busy_o) seen = 1'b1;
      end
      check("unknown_op_ignored", {31'd0, seen, hi_o, lo_o}, {32'd0, 32'd0, 32'd12});
`endif

      // ---- reset in cycle 10 of a DIV clears everything
      @(negedge clk);
      start_i = 1'b1; op_i = DIV; a_i = 32'h8000_0000; b_i = 32'd3;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("reset_mid_div", {30'd0, busy_o, done_o, hi_o, lo_o}, 64'd0);
      seen = 1'b0;
      repeat (DLAT + 4) begin
         @(negedge clk);
         if (done_o || busy_o) seen = 1'b1;
      end
      check("reset_mid_div_quiet", 64'(seen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
